// File: rtl/inst_mem_axi_slave.sv
// inst_mem_axi_slave: instruction memory behind an AXI-style read channel.
// Each accepted AR request returns one line-aligned, incrementing burst of BEATS
// words. A preload port writes single words at any time.
// Optional feature macro: INST_MEM_WAIT_STATE_EN inserts READ_LATENCY wait
// cycles between the address handshake and the first beat.
module inst_mem_axi_slave #(
    parameter int DATA_LENGTH  = 32,
    parameter int LINE_SIZE    = 64,
    parameter int MEM_DEPTH    = 4096,
    parameter int READ_LATENCY = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            ARADDR,
    input  logic                   ARVALID,
    output logic                   ARREADY,
    output logic [DATA_LENGTH-1:0] RDATA,
    output logic                   RVALID,
    input  logic                   RREADY,
    output logic                   RLAST,
    output logic [1:0]             RRESP,
    input  logic                   load_en,
    input  logic [31:0]            load_addr,
    input  logic [DATA_LENGTH-1:0] load_data
);
    localparam int BEATS  = LINE_SIZE / (DATA_LENGTH / 8);
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int ADDR_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(BEATS - 1);
    localparam logic [29:0]       LINE_MASK   = ~30'(BEATS - 1);
    localparam logic [29:0]       DEPTH_WORDS = 30'(MEM_DEPTH);
    localparam logic [1:0]        RESP_OKAY   = 2'b00;
    localparam logic [1:0]        RESP_SLVERR = 2'b10;

`ifdef INST_MEM_WAIT_STATE_EN
    typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;
    localparam int WAIT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);
    logic [WAIT_W-1:0] wait_reg, wait_next;
`else
    typedef enum logic [0:0] {IDLE, BURST} state_t;
`endif

    state_t             state_reg, state_next;
    logic [BEAT_W-1:0]  beat_reg, beat_next;   // index of the beat currently presented
    logic [29:0]        base_reg, base_next;   // line-aligned word index of the burst

    // A "launch" samples memory for the beat that appears on R next cycle.
    logic               launch;
    logic [29:0]        launch_idx;
    logic               launch_last;
    logic               finish;

    logic [29:0]        ar_base;
    logic [29:0]        load_idx;

    logic [DATA_LENGTH-1:0] mem [MEM_DEPTH];

    // Byte-offset bits are meaningless for word-aligned accesses.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, ARADDR[1:0], load_addr[1:0]};

    assign ar_base  = ARADDR[31:2] & LINE_MASK;
    assign load_idx = load_addr[31:2];

    assign ARREADY = (state_reg == IDLE);
    assign RVALID  = (state_reg == BURST);

    // State, beat counter and burst base registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            beat_reg  <= '0;
            base_reg  <= '0;
`ifdef INST_MEM_WAIT_STATE_EN
            wait_reg  <= '0;
`endif
        end else begin
            state_reg <= state_next;
            beat_reg  <= beat_next;
            base_reg  <= base_next;
`ifdef INST_MEM_WAIT_STATE_EN
            wait_reg  <= wait_next;
`endif
        end
    end

    // Next-state logic and beat launch decisions.
    always_comb begin
        state_next  = state_reg;
        beat_next   = beat_reg;
        base_next   = base_reg;
`ifdef INST_MEM_WAIT_STATE_EN
        wait_next   = wait_reg;
`endif
        launch      = 1'b0;
        launch_idx  = base_reg;
        launch_last = 1'b0;
        finish      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (ARVALID) begin
                    base_next = ar_base;
                    beat_next = '0;
`ifdef INST_MEM_WAIT_STATE_EN
                    if (READ_LATENCY == 0) begin
                        launch      = 1'b1;
                        launch_idx  = ar_base;
                        launch_last = (BEATS == 1);
                        state_next  = BURST;
                    end else begin
                        wait_next  = '0;
                        state_next = WAIT;
                    end
`else
                    launch      = 1'b1;
                    launch_idx  = ar_base;
                    launch_last = (BEATS == 1);
                    state_next  = BURST;
`endif
                end
            end
`ifdef INST_MEM_WAIT_STATE_EN
            WAIT: begin
                if (wait_reg == WAIT_LAST) begin
                    launch      = 1'b1;
                    launch_idx  = base_reg;
                    launch_last = (BEATS == 1);
                    state_next  = BURST;
                end else begin
                    wait_next = wait_reg + 1'b1;
                end
            end
`endif
            BURST: begin
                if (RREADY) begin
                    if (beat_reg == LAST_BEAT) begin
                        finish     = 1'b1;
                        state_next = IDLE;
                    end else begin
                        beat_next   = beat_reg + 1'b1;
                        launch      = 1'b1;
                        launch_idx  = base_reg + 30'(beat_next);
                        launch_last = (beat_next == LAST_BEAT);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Preload write port; words beyond the array are silently dropped.
    always_ff @(posedge clk) begin
        if (load_en && (load_idx < DEPTH_WORDS)) begin
            mem[load_idx[ADDR_W-1:0]] <= load_data;
        end
    end

    // Registered R payload: captured at launch, held untouched during stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RDATA <= '0;
            RLAST <= 1'b0;
            RRESP <= RESP_OKAY;
        end else if (launch) begin
            RLAST <= launch_last;
            if (launch_idx < DEPTH_WORDS) begin
                RDATA <= mem[launch_idx[ADDR_W-1:0]];
                RRESP <= RESP_OKAY;
            end else begin
                RDATA <= '0;
                RRESP <= RESP_SLVERR;
            end
        end else if (finish) begin
            RLAST <= 1'b0;
            RRESP <= RESP_OKAY;
        end
    end

endmodule
